// File: rtl/boundary_writer.sv
// boundary_writer
// Producer side of the scrolling-boundary row store. Each accepted scroll tick
// produces one river-boundary row: a random-walk left/right bank plus an
// optional island centred in the channel. The row word is registered, then the
// toggle-style shift strobe flips, and the word is held for HOLD_CYCLES more
// cycles so boundary_mem can detect the toggle and write it.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   enable      when 0, scroll_tick is ignored and not latched
//   scroll_tick one-cycle pulse requesting one new row
//   seed        LFSR seed, sampled while reset is high (0 selects SEED_DEFAULT)
//   row_data    {left, right, isl_left, isl_right}, 10 bits each;
//               isl_left == isl_right means no island
//   shift       toggles once per new row
//   busy        high while a row is being generated or held
//   overflow    sticky; set when a tick is dropped
//   state_dbg   current FSM state encoding (IDLE=0 GEN=1 CLAMP=2 PRESENT=3 HOLD=4)
//
// Handshake: scroll_tick is a fire-and-forget request with no ready. A tick is
// registered first, so the FSM reacts one cycle after the edge that sampled
// it. While busy, one request is remembered in pending; a further request
// while pending is set is dropped and flags overflow.
module boundary_writer #(
  parameter int SCREEN_W     = 640,
  parameter int MARGIN       = 16,
  parameter int STEP         = 2,
  parameter int MIN_WIDTH    = 96,
  parameter int MAX_WIDTH    = 400,
  parameter int ISLAND_MIN_W = 200,
  parameter int ISLAND_LEN   = 64,
  parameter int HOLD_CYCLES  = 3,
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        scroll_tick,
  input  logic [15:0] seed,
  output logic [39:0] row_data,
  output logic        shift,
  output logic        busy,
  output logic        overflow,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GEN     = 3'd1,
    CLAMP   = 3'd2,
    PRESENT = 3'd3,
    HOLD    = 3'd4
  } state_t;

  localparam logic [39:0] RESET_ROW = {10'd200, 10'd440, 10'd0, 10'd0};

  localparam logic signed [10:0] L_MARGIN  = 11'(MARGIN);
  localparam logic signed [10:0] L_RMAX    = 11'(SCREEN_W - 1 - MARGIN);
  localparam logic signed [10:0] L_STEP    = 11'(STEP);
  localparam logic signed [10:0] L_MIN_W   = 11'(MIN_WIDTH);
  localparam logic signed [10:0] L_MAX_W   = 11'(MAX_WIDTH);
  localparam logic signed [10:0] L_ISL_MIN = 11'(ISLAND_MIN_W);

  state_t state, state_nx;
  logic   tick_q;
  logic   pending, pending_nx;
  logic   overflow_nx;

  logic [15:0] lfsr, lfsr_next;
  logic [3:0]  hold_cnt;
  logic        island_on, island_on_nx;
  logic [6:0]  island_cnt, island_cnt_nx;

  logic signed [10:0] cand_l, cand_r;
  logic signed [10:0] prev_l, prev_r;
  logic signed [10:0] dl, dr;
  logic signed [10:0] c1_l, c1_r, c2_l, c2_r, c3_r;
  logic signed [10:0] width;
  logic signed [11:0] edge_sum;
  logic signed [10:0] center, quarter;
  logic signed [10:0] isl_l, isl_r;

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  assign prev_l = $signed({1'b0, row_data[39:30]});
  assign prev_r = $signed({1'b0, row_data[29:20]});

  // Galois form of x^16+x^14+x^13+x^11, shifting right.
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  // Bank deltas: 00 moves left, 11 moves right, the two middle codes hold.
  always_comb begin
    dl = 11'sd0;
    dr = 11'sd0;
    case (lfsr[1:0])
      2'b00:   dl = -L_STEP;
      2'b11:   dl = L_STEP;
      default: dl = 11'sd0;
    endcase
    case (lfsr[3:2])
      2'b00:   dr = -L_STEP;
      2'b11:   dr = L_STEP;
      default: dr = 11'sd0;
    endcase
  end

  // Clamp and island computation on the candidate edges latched in GEN.
  always_comb begin
    c1_l = (cand_l < L_MARGIN) ? L_MARGIN : cand_l;
    c1_r = (cand_r > L_RMAX)   ? L_RMAX   : cand_r;

    // Too narrow: keep last row's banks rather than pinching the channel.
    if ((c1_r - c1_l) < L_MIN_W) begin
      c2_l = prev_l;
      c2_r = prev_r;
    end else begin
      c2_l = c1_l;
      c2_r = c1_r;
    end

    c3_r  = ((c2_r - c2_l) > L_MAX_W) ? (c2_l + L_MAX_W) : c2_r;
    width = c3_r - c2_l;

    island_on_nx  = island_on;
    island_cnt_nx = island_cnt;
    if (!island_on) begin
      if ((width >= L_ISL_MIN) && (lfsr[7:4] == 4'd0)) begin
        island_on_nx  = 1'b1;
        island_cnt_nx = 7'(ISLAND_LEN);
      end
    end else begin
      // The row on which the count runs out already shows open water.
      island_cnt_nx = island_cnt - 7'd1;
      if ((island_cnt_nx == 7'd0) || (width < L_ISL_MIN)) begin
        island_on_nx  = 1'b0;
        island_cnt_nx = 7'd0;
      end
    end

    // left+right can exceed the 11-bit signed range, so sum one bit wider.
    edge_sum = {c2_l[10], c2_l} + {c3_r[10], c3_r};
    center   = edge_sum[11:1];
    quarter  = width >>> 2;
    if (island_on_nx) begin
      isl_l = center - quarter;
      isl_r = center + quarter;
    end else begin
      isl_l = 11'sd0;
      isl_r = 11'sd0;
    end
  end

  // Next-state, pending and overflow.
  always_comb begin
    state_nx    = state;
    pending_nx  = pending;
    overflow_nx = overflow;
    case (state)
      IDLE: begin
        if (tick_q || pending) begin
          state_nx = GEN;
          // A fresh tick arriving while a pending one is consumed stays queued.
          pending_nx = tick_q && pending;
        end
      end
      GEN:     state_nx = CLAMP;
      CLAMP:   state_nx = PRESENT;
      PRESENT: state_nx = HOLD;
      HOLD: begin
        if (hold_cnt == 4'(HOLD_CYCLES - 1)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if ((state != IDLE) && tick_q) begin
      if (pending) overflow_nx = 1'b1;
      else         pending_nx  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tick_q     <= 1'b0;
      pending    <= 1'b0;
      overflow   <= 1'b0;
      shift      <= 1'b0;
      row_data   <= RESET_ROW;
      lfsr       <= (seed == 16'h0000) ? SEED_DEFAULT : seed;
      hold_cnt   <= 4'd0;
      island_on  <= 1'b0;
      island_cnt <= 7'd0;
      cand_l     <= 11'sd0;
      cand_r     <= 11'sd0;
    end else begin
      state    <= state_nx;
      pending  <= pending_nx;
      overflow <= overflow_nx;
      tick_q   <= scroll_tick && enable;
      case (state)
        GEN: begin
          cand_l <= prev_l + dl;
          cand_r <= prev_r + dr;
        end
        CLAMP: begin
          row_data   <= {c2_l[9:0], c3_r[9:0], isl_l[9:0], isl_r[9:0]};
          lfsr       <= lfsr_next;
          island_on  <= island_on_nx;
          island_cnt <= island_cnt_nx;
        end
        PRESENT: begin
          shift    <= ~shift;
          hold_cnt <= 4'd0;
        end
        HOLD: hold_cnt <= hold_cnt + 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_boundary_writer.sv
// Testbench for boundary_writer: directed latency/pending/enable/reset tests
// with hand-computed rows, plus a long seeded run checked against the row
// invariants. Rows are checked by a monitor that fires on every shift toggle.
module tb_boundary_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        scroll_tick = 1'b0;
  logic [15:0] seed = 16'h0000;
  logic [39:0] row_data;
  logic        shift;
  logic        busy;
  logic        overflow;
  logic [2:0]  state_dbg;

  localparam logic [39:0] RESET_ROW = {10'd200, 10'd440, 10'd0, 10'd0};
  // Hand-derived from LFSR 0xACE1 -> 0xE270 -> 0x7138.
  localparam logic [39:0] ROW1 = {10'd200, 10'd438, 10'd0, 10'd0};
  localparam logic [39:0] ROW2 = {10'd198, 10'd436, 10'd0, 10'd0};
  localparam logic [39:0] ROW3 = {10'd196, 10'd436, 10'd0, 10'd0};

  int tests = 0;
  int fails = 0;
  int toggles = 0;
  int islands_seen = 0;
  int isl_run = 0;
  int isl_max = 0;
  logic [39:0] exp_q[$];

  boundary_writer dut (
    .clk(clk), .reset(reset), .enable(enable), .scroll_tick(scroll_tick),
    .seed(seed), .row_data(row_data), .shift(shift), .busy(busy),
    .overflow(overflow), .state_dbg(state_dbg)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic tick_once();
    @(negedge clk);
    scroll_tick = 1'b1;
    @(negedge clk);
    scroll_tick = 1'b0;
  endtask

  task automatic do_reset(input logic [15:0] s);
    @(negedge clk);
    seed = s;
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
  endtask

  // Monitor / scoreboard: every shift toggle presents a row.
  logic        last_shift = 1'b0;
  logic [39:0] prev_row = RESET_ROW;

  always @(negedge clk) begin
    int l, r, il, ir, pl, pr;
    if (reset) begin
      last_shift = 1'b0;
      prev_row   = RESET_ROW;
      isl_run    = 0;
    end else if (shift !== last_shift) begin
      last_shift = shift;
      toggles++;
      if (exp_q.size() > 0) check("row_data", row_data, exp_q.pop_front());
      l  = int'(row_data[39:30]);
      r  = int'(row_data[29:20]);
      il = int'(row_data[19:10]);
      ir = int'(row_data[9:0]);
      pl = int'(prev_row[39:30]);
      pr = int'(prev_row[29:20]);
      check("inv_left_margin", 40'(l >= 16), 40'd1);
      check("inv_right_margin", 40'(r <= 623), 40'd1);
      check("inv_width", 40'((r - l >= 96) && (r - l <= 400)), 40'd1);
      check("inv_step", 40'((l - pl <= 2) && (pl - l <= 2) && (r - pr <= 2) && (pr - r <= 2)), 40'd1);
      if (il != ir) begin
        check("inv_island", 40'((l < il) && (il < ir) && (ir < r)), 40'd1);
        isl_run++;
        if (isl_run == 1) islands_seen++;
        if (isl_run > isl_max) isl_max = isl_run;
      end else begin
        check("inv_no_island", 40'(il == 0 && ir == 0), 40'd1);
        isl_run = 0;
      end
      prev_row = row_data;
    end
  end

  // Stimulus
  initial begin
    int t0;
    // Reset with seed 0 (loads 0xACE1).
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("reset_shift", shift, 0);
    check("reset_busy", busy, 0);
    check("reset_overflow", overflow, 0);
    check("reset_row", row_data, RESET_ROW);

    // Single tick latency profile.
    exp_q.push_back(ROW1);
    tick_once();                               // now at T+0.5
    check("lat_busy_T0", busy, 0);
    @(negedge clk);                            // T+1.5
    check("lat_busy_T1", busy, 1);
    check("lat_row_T1", row_data, RESET_ROW);
    @(negedge clk);                            // T+2.5
    check("lat_row_T2", row_data, RESET_ROW);
    check("lat_shift_T2", shift, 0);
    @(negedge clk);                            // T+3.5
    check("lat_row_T3", row_data, ROW1);
    check("lat_shift_T3", shift, 0);
    @(negedge clk);                            // T+4.5
    check("lat_shift_T4", shift, 1);
    repeat (2) begin
      @(negedge clk);                          // T+5.5, T+6.5
      check("lat_hold_busy", busy, 1);
      check("lat_hold_row", row_data, ROW1);
    end
    @(negedge clk);                            // T+7.5
    check("lat_busy_T7", busy, 0);
    check("lat_toggles", 40'(toggles), 40'd1);

    // Pending and overflow: ticks at T, T+2, T+4.
    t0 = toggles;
    exp_q.push_back(ROW2);
    exp_q.push_back(ROW3);
    tick_once();
    tick_once();
    check("ovf_before_third", overflow, 0);
    tick_once();
    repeat (30) @(negedge clk);
    check("ovf_set", overflow, 1);
    check("ovf_toggles", 40'(toggles - t0), 40'd2);
    check("ovf_idle", busy, 0);
    check("ovf_queue_empty", 40'(exp_q.size()), 40'd0);
    repeat (10) @(negedge clk);
    check("ovf_sticky", overflow, 1);

    // Reset clears overflow; enable=0 ignores ticks.
    do_reset(16'h0000);
    check("rst2_overflow", overflow, 0);
    check("rst2_row", row_data, RESET_ROW);
    enable = 1'b0;
    t0 = toggles;
    repeat (10) begin
      tick_once();
      @(negedge clk);
      check("dis_busy", busy, 0);
    end
    repeat (10) @(negedge clk);
    check("dis_toggles", 40'(toggles - t0), 40'd0);
    check("dis_overflow", overflow, 0);
    check("dis_row", row_data, RESET_ROW);
    enable = 1'b1;

    // Reset asserted during HOLD, then a first row from the reloaded seed.
    exp_q.push_back(ROW1);
    tick_once();
    repeat (5) @(negedge clk);                 // T+5.5, in HOLD
    check("hold_shift", shift, 1);
    #2 reset = 1'b1;
    #1;
    check("async_shift", shift, 0);
    check("async_row", row_data, RESET_ROW);
    check("async_busy", busy, 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    t0 = toggles;
    exp_q.push_back(ROW1);
    tick_once();
    repeat (12) @(negedge clk);
    check("reload_toggles", 40'(toggles - t0), 40'd1);
    check("reload_queue_empty", 40'(exp_q.size()), 40'd0);

    // Long seeded run checked by the monitor's invariants.
    do_reset(16'h1234);
    t0 = toggles;
    isl_max = 0;
    islands_seen = 0;
    for (int i = 0; i < 2000; i++) begin
      tick_once();
      repeat (8) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check("run_toggles", 40'(toggles - t0), 40'd2000);
    check("run_island_seen", 40'(islands_seen > 0), 40'd1);
    check("run_island_len", 40'(isl_max <= 64), 40'd1);
    check("run_overflow", overflow, 0);
    check("final_queue_empty", 40'(exp_q.size()), 40'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
